a25_mem_arbiter: RTL and testbench
==================================

Name: a25_mem_arbiter

Overview:
- Shares one Wishbone-style memory port between the a25 execute stage's instruction-fetch side and data-access side.
- Data side has priority by default. A streak counter stops instruction starvation.
- Exclusive data accesses lock the bus until the exclusive sequence ends.
- Sits between the execute stage (iaddress/daddress requests) and the cache/wishbone bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte enables are DATA_W/8
MAX_D_STREAK, 4, consecutive data grants allowed while an instruction request waits
TIMEOUT_CYCLES, 64, cycles without ack before abort (only with A25_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_iaddress  in  ADDR_W  instruction fetch address
i_iaddress_valid  in  1  instruction request; held until o_i_done
o_i_done  out  1  instruction access complete (one-cycle pulse)
o_i_read_data  out  DATA_W  fetch data, valid with o_i_done
i_daddress  in  ADDR_W  data address
i_daddress_valid  in  1  data request; held until o_d_done
i_write_enable  in  1  data write
i_byte_enable  in  DATA_W/8  data byte lanes
i_write_data  in  DATA_W  store data
i_exclusive  in  1  exclusive (swap) access; requests bus lock
o_d_done  out  1  data access complete (one-cycle pulse)
o_d_read_data  out  DATA_W  load data, valid with o_d_done
o_wb_adr  out  ADDR_W  bus address
o_wb_sel  out  DATA_W/8  bus byte select
o_wb_we  out  1  bus write
o_wb_dat  out  DATA_W  bus write data
o_wb_cyc  out  1  bus cycle / lock
o_wb_stb  out  1  bus strobe
i_wb_ack  in  1  bus acknowledge
i_wb_dat  in  DATA_W  bus read data
o_bus_err  out  1  timeout abort flag, valid with done

Behaviour:
- Interface decision: one clock domain, clock `clk`; reset `reset` is synchronous, active-high.
- Reset values:
  - All o_wb_* outputs are 0.
  - o_i_done, o_d_done and o_bus_err are 0.
  - Read data outputs are 0.
  - State is IDLE; streak counter and timeout counter are 0.
  - Reset mid-access drops cyc/stb immediately (next edge) and generates no done pulse.
- States: IDLE, I_ACC, D_ACC, D_LOCK.
- IDLE, granting:
  - With both valids sampled at cycle N, data wins unless streak == MAX_D_STREAK.
  - Winner's addr/sel/we/dat are registered onto o_wb_* at N+1 with cyc=stb=1.
  - An instruction grant drives sel all-ones and we=0.
- Streak counter:
  - Increments on each data grant made while i_iaddress_valid=1, saturating at MAX_D_STREAK.
  - Clears on any instruction grant.
  - Clears on a data grant made while no instruction request is pending.
- I_ACC / D_ACC:
  - Hold o_wb_* stable until i_wb_ack.
  - In the ack cycle, the matching done=1 and read_data=i_wb_dat (combinational pass-through).
  - Registered on the ack edge: stb=0, and cyc=0 unless the lock is set.
  - Next state is IDLE, or D_LOCK after an exclusive data access.
- Requester rules:
  - The requester deasserts valid, or presents a new request, in the cycle after done.
  - The arbiter samples valids again one cycle after ack, so an ack cycle never re-grants.
- Lock:
  - Set when a data access with i_exclusive=1 is acked.
  - D_LOCK keeps cyc=1, stb=0 and grants only the data side; instruction requests wait.
  - A data grant from D_LOCK goes to D_ACC with cyc held.
  - The lock clears when a data access with i_exclusive=0 is acked; cyc=0 next cycle.
- Ignored ack: i_wb_ack in IDLE or D_LOCK is ignored.
- Write data: o_d_read_data is don't-care for writes but still driven from i_wb_dat.

Optional Feature:
- Macro A25_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in I_ACC/D_ACC and resets on every grant.
  - On reaching TIMEOUT_CYCLES without ack: done pulses for the owning side, o_bus_err=1 with it, and read_data=0.
  - cyc/stb drop and the lock is cleared; next state is IDLE.
  - An ack in the same cycle as the timeout wins: normal done, o_bus_err=0.
- Undefined: no counter; o_bus_err is tied to 0 and the arbiter waits indefinitely.

Decomposition:
- Package a25_arb_pkg holds:
  - the state enum (IDLE, I_ACC, D_ACC, D_LOCK);
  - localparam widths for the streak and timeout counters, computed with $clog2;
  - a grant-select enum (GNT_I, GNT_D).
- One sub-module, a25_arb_timeout: a loadable down-counter with an expiry pulse, instantiated only under A25_ARB_TIMEOUT_EN.

Test Plan:
1. Instruction only, addr 0x100, ack at 3rd bus cycle, i_wb_dat=0xE3A00001 -> cyc/stb 1 cycle after request, sel=0xF, we=0; o_i_done=1 with data 0xE3A00001; cyc=0 next cycle.
2. Both valid continuously, data requests back-to-back, ack in 1 cycle, MAX_D_STREAK=4 -> grant order D,D,D,D,I; streak clears after I.
3. Exclusive read 0x2000 then exclusive=0 write 0x2000 data 0x55 sel=0x1, instruction pending throughout -> cyc stays 1 across both accesses; instruction granted only after lock clears.
4. Reset asserted during D_ACC before ack -> next cycle all o_wb_* = 0, no done pulse, state IDLE.
5. With A25_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, data read never acked -> o_d_done=1 and o_bus_err=1 at the 8th access cycle, data 0, cyc=0 next.
6. With A25_ARB_TIMEOUT_EN, ack coincides with the timeout cycle -> done=1, o_bus_err=0, data=i_wb_dat.

Source files
------------

// File: rtl/a25_arb_pkg.sv
// a25 memory arbiter shared types: FSM states, grant select, counter widths.
// Timeout support is enabled with the A25_ARB_TIMEOUT_EN macro.
package a25_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    I_ACC,
    D_ACC,
    D_LOCK
  } arb_state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_gnt_e;

  localparam int ARB_MAX_D_STREAK   = 4;
  localparam int ARB_TIMEOUT_CYCLES = 64;
  localparam int ARB_STREAK_W = $clog2(ARB_MAX_D_STREAK + 1);
  localparam int ARB_TMO_W    = $clog2(ARB_TIMEOUT_CYCLES + 1);

  function automatic int arb_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/a25_arb_timeout.sv
// Access watchdog: loadable down-counter that flags expiry while running.
// Instantiated by a25_mem_arbiter only when A25_ARB_TIMEOUT_EN is defined.
module a25_arb_timeout
  import a25_arb_pkg::*;
#(
  parameter int CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);

  localparam int W = arb_cnt_w(CYCLES);
  localparam logic [W-1:0] LOAD_V = W'(CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_V;
    end else if (i_run && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // loaded with CYCLES-1 so zero is reached in the CYCLES-th access cycle
  assign o_expire = i_run & ~i_load & (r_cnt == '0);

endmodule

// File: rtl/a25_mem_arbiter.sv
// a25 memory arbiter: shares one Wishbone port between fetch and data sides.
// Define A25_ARB_TIMEOUT_EN to abort accesses that are never acknowledged.
module a25_mem_arbiter
  import a25_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   i_iaddress,
  input  logic                i_iaddress_valid,
  output logic                o_i_done,
  output logic [DATA_W-1:0]   o_i_read_data,
  input  logic [ADDR_W-1:0]   i_daddress,
  input  logic                i_daddress_valid,
  input  logic                i_write_enable,
  input  logic [DATA_W/8-1:0] i_byte_enable,
  input  logic [DATA_W-1:0]   i_write_data,
  input  logic                i_exclusive,
  output logic                o_d_done,
  output logic [DATA_W-1:0]   o_d_read_data,
  output logic [ADDR_W-1:0]   o_wb_adr,
  output logic [DATA_W/8-1:0] o_wb_sel,
  output logic                o_wb_we,
  output logic [DATA_W-1:0]   o_wb_dat,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  input  logic                i_wb_ack,
  input  logic [DATA_W-1:0]   i_wb_dat,
  output logic                o_bus_err
);

  localparam int SEL_W = DATA_W / 8;
  localparam int SW    = arb_cnt_w(MAX_D_STREAK);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_e          r_state, w_state;
  logic [ADDR_W-1:0]   r_adr, w_adr;
  logic [SEL_W-1:0]    r_sel, w_sel;
  logic                r_we, w_we;
  logic [DATA_W-1:0]   r_dat, w_dat;
  logic                r_cyc, w_cyc;
  logic                r_stb, w_stb;
  logic                r_lock, w_lock;
  logic                r_excl, w_excl;
  logic [SW-1:0]       r_streak, w_streak;

  logic     w_grant;
  arb_gnt_e w_gnt;
  logic     w_d_wins;
  logic     w_i_wins;
  logic     w_run;
  logic     w_tmo;
  logic     w_i_ack;
  logic     w_d_ack;
  logic     w_i_end;
  logic     w_d_end;

  // data wins unless the fetch side has already waited MAX_D_STREAK grants
  assign w_d_wins = i_daddress_valid &
                    (~i_iaddress_valid | (r_streak != STREAK_MAX));
  assign w_i_wins = i_iaddress_valid & ~w_d_wins;
  assign w_run    = (r_state == I_ACC) | (r_state == D_ACC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_adr    <= '0;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_dat    <= '0;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_lock   <= 1'b0;
      r_excl   <= 1'b0;
      r_streak <= '0;
    end else begin
      r_state  <= w_state;
      r_adr    <= w_adr;
      r_sel    <= w_sel;
      r_we     <= w_we;
      r_dat    <= w_dat;
      r_cyc    <= w_cyc;
      r_stb    <= w_stb;
      r_lock   <= w_lock;
      r_excl   <= w_excl;
      r_streak <= w_streak;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_adr    = r_adr;
    w_sel    = r_sel;
    w_we     = r_we;
    w_dat    = r_dat;
    w_cyc    = r_cyc;
    w_stb    = r_stb;
    w_lock   = r_lock;
    w_excl   = r_excl;
    w_streak = r_streak;
    w_grant  = 1'b0;
    w_gnt    = GNT_D;
    unique case (r_state)
      IDLE: begin
        unique case (1'b1)
          w_d_wins: begin
            w_grant = 1'b1;
            w_gnt   = GNT_D;
          end
          w_i_wins: begin
            w_grant = 1'b1;
            w_gnt   = GNT_I;
          end
          default: ;
        endcase
      end
      D_LOCK: begin
        if (i_daddress_valid) begin
          w_grant = 1'b1;
          w_gnt   = GNT_D;
        end
      end
      I_ACC, D_ACC: begin
        if (i_wb_ack) begin
          w_stb = 1'b0;
          if (r_state == D_ACC) w_lock = r_excl;
          w_cyc   = w_lock;
          w_state = w_lock ? D_LOCK : IDLE;
        end else if (w_tmo) begin
          w_stb   = 1'b0;
          w_cyc   = 1'b0;
          w_lock  = 1'b0;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
    if (w_grant) begin
      w_cyc = 1'b1;
      w_stb = 1'b1;
      if (w_gnt == GNT_D) begin
        w_state  = D_ACC;
        w_adr    = i_daddress;
        w_sel    = i_byte_enable;
        w_we     = i_write_enable;
        w_dat    = i_write_data;
        w_excl   = i_exclusive;
        if (!i_iaddress_valid) w_streak = '0;
        else if (r_streak != STREAK_MAX) w_streak = r_streak + 1'b1;
      end else begin
        w_state  = I_ACC;
        w_adr    = i_iaddress;
        w_sel    = '1;
        w_we     = 1'b0;
        w_dat    = '0;
        w_excl   = 1'b0;
        w_streak = '0;
      end
    end
  end

`ifdef A25_ARB_TIMEOUT_EN
  a25_arb_timeout #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_grant),
    .i_run   (w_run),
    .o_expire(w_tmo)
  );
  assign o_bus_err = (w_i_end | w_d_end) & ~i_wb_ack;
`else
  logic w_unused_tmo;
  assign w_tmo        = 1'b0;
  assign w_unused_tmo = w_run ^ (TIMEOUT_CYCLES > 0);
  assign o_bus_err    = 1'b0;
`endif

  assign w_i_ack = (r_state == I_ACC) & i_wb_ack & ~reset;
  assign w_d_ack = (r_state == D_ACC) & i_wb_ack & ~reset;
  assign w_i_end = (r_state == I_ACC) & (i_wb_ack | w_tmo) & ~reset;
  assign w_d_end = (r_state == D_ACC) & (i_wb_ack | w_tmo) & ~reset;

  assign o_i_done      = w_i_end;
  assign o_d_done      = w_d_end;
  assign o_i_read_data = w_i_ack ? i_wb_dat : '0;
  assign o_d_read_data = w_d_ack ? i_wb_dat : '0;

  assign o_wb_adr = r_adr;
  assign o_wb_sel = r_sel;
  assign o_wb_we  = r_we;
  assign o_wb_dat = r_dat;
  assign o_wb_cyc = r_cyc;
  assign o_wb_stb = r_stb;

endmodule

// File: tb/tb_a25_mem_arbiter.sv
// Directed cycle-table bench for a25_mem_arbiter.
// Timeout sequences run only when A25_ARB_TIMEOUT_EN is defined.
module tb_a25_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] i_iaddress;
  logic        i_iaddress_valid;
  logic        o_i_done;
  logic [31:0] o_i_read_data;
  logic [31:0] i_daddress;
  logic        i_daddress_valid;
  logic        i_write_enable;
  logic [3:0]  i_byte_enable;
  logic [31:0] i_write_data;
  logic        i_exclusive;
  logic        o_d_done;
  logic [31:0] o_d_read_data;
  logic [31:0] o_wb_adr;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic [31:0] o_wb_dat;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        i_wb_ack;
  logic [31:0] i_wb_dat;
  logic        o_bus_err;

  a25_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_D_STREAK(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_iaddress      (i_iaddress),
    .i_iaddress_valid(i_iaddress_valid),
    .o_i_done        (o_i_done),
    .o_i_read_data   (o_i_read_data),
    .i_daddress      (i_daddress),
    .i_daddress_valid(i_daddress_valid),
    .i_write_enable  (i_write_enable),
    .i_byte_enable   (i_byte_enable),
    .i_write_data    (i_write_data),
    .i_exclusive     (i_exclusive),
    .o_d_done        (o_d_done),
    .o_d_read_data   (o_d_read_data),
    .o_wb_adr        (o_wb_adr),
    .o_wb_sel        (o_wb_sel),
    .o_wb_we         (o_wb_we),
    .o_wb_dat        (o_wb_dat),
    .o_wb_cyc        (o_wb_cyc),
    .o_wb_stb        (o_wb_stb),
    .i_wb_ack        (i_wb_ack),
    .i_wb_dat        (i_wb_dat),
    .o_bus_err       (o_bus_err)
  );

  typedef struct {
    logic        rst, iv, dv, ex, we;
    logic [3:0]  be;
    logic [31:0] da, wdat;
    logic        ack;
    logic [31:0] wbd;
    logic        cyc, stb, chk;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        ewe;
    logic [31:0] edat;
    logic        id, dd;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rst, iv, dv, ex, we, input logic [3:0] be,
    input logic [31:0] da, wdat, input logic ack, input logic [31:0] wbd,
    input logic cyc, stb, c, input logic [31:0] adr, input logic [3:0] sel,
    input logic ewe, input logic [31:0] edat, input logic id, dd,
    input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.iv = iv; v.dv = dv; v.ex = ex; v.we = we; v.be = be;
    v.da = da; v.wdat = wdat; v.ack = ack; v.wbd = wbd;
    v.cyc = cyc; v.stb = stb; v.chk = c; v.adr = adr; v.sel = sel;
    v.ewe = ewe; v.edat = edat; v.id = id; v.dd = dd; v.rd = rd;
    return v;
  endfunction

  localparam logic [31:0] IA = 32'h100;
  localparam logic [31:0] DA = 32'h200;
  localparam logic [31:0] XA = 32'h2000;

  initial begin
    // instruction only, ack on third bus cycle
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0, 1,1,1,IA,4'hF,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0, 1,1,1,IA,4'hF,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,32'hE3A00001,
                     1,1,1,IA,4'hF,0,0, 1,0,32'hE3A00001));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
    // both valid: D,D,D,D then I
    for (int k = 1; k <= 4; k++) begin
      tbl.push_back(mk(0,1,1,0,0,4'hF,DA,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
      tbl.push_back(mk(0,1,1,0,0,4'hF,DA,0,1,32'hD0+k,
                       1,1,1,DA,4'hF,0,0, 0,1,32'hD0+k));
    end
    tbl.push_back(mk(0,1,1,0,0,4'hF,DA,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0,4'hF,DA,0,1,32'h11,
                     1,1,1,IA,4'hF,0,0, 1,0,32'h11));
    tbl.push_back(mk(0,1,1,0,0,4'hF,DA,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,0,0,4'hF,DA,0,1,32'hD5,
                     1,1,1,DA,4'hF,0,0, 0,1,32'hD5));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
    // exclusive read then unlocking write, fetch pending throughout
    tbl.push_back(mk(0,1,1,1,0,4'hF,XA,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,1,0,4'hF,XA,0,1,32'hABCD,
                     1,1,1,XA,4'hF,0,0, 0,1,32'hABCD));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,32'h9,
                     1,0,1,XA,4'hF,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,0,1,4'h1,XA,32'h55,0,0,
                     1,0,1,XA,4'hF,0,0, 0,0,0));
    tbl.push_back(mk(0,1,1,0,1,4'h1,XA,32'h55,1,0,
                     1,1,1,XA,4'h1,1,32'h55, 0,1,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,32'h1234,
                     1,1,1,IA,4'hF,0,0, 1,0,32'h1234));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,32'h999, 0,0,0,0,0,0,0, 0,0,0));
    // reset in the middle of a data access
    tbl.push_back(mk(0,0,1,0,0,4'hF,32'h300,0,0,0, 0,0,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'hF,32'h300,0,0,0,
                     1,1,1,32'h300,4'hF,0,0, 0,0,0));
    tbl.push_back(mk(1,0,1,0,0,4'hF,32'h300,0,0,0,
                     1,1,1,32'h300,4'hF,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,32'h5, 0,0,1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0));

    reset = 1'b1;
    i_iaddress = IA;
    i_iaddress_valid = 1'b0;
    i_daddress = '0;
    i_daddress_valid = 1'b0;
    i_write_enable = 1'b0;
    i_byte_enable = '0;
    i_write_data = '0;
    i_exclusive = 1'b0;
    i_wb_ack = 1'b0;
    i_wb_dat = '0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset            = tbl[i].rst;
      i_iaddress_valid = tbl[i].iv;
      i_daddress_valid = tbl[i].dv;
      i_exclusive      = tbl[i].ex;
      i_write_enable   = tbl[i].we;
      i_byte_enable    = tbl[i].be;
      i_daddress       = tbl[i].da;
      i_write_data     = tbl[i].wdat;
      i_wb_ack         = tbl[i].ack;
      i_wb_dat         = tbl[i].wbd;
      #1;
      chk($sformatf("r%0d cyc", i), 32'(o_wb_cyc), 32'(tbl[i].cyc));
      chk($sformatf("r%0d stb", i), 32'(o_wb_stb), 32'(tbl[i].stb));
      chk($sformatf("r%0d i_done", i), 32'(o_i_done), 32'(tbl[i].id));
      chk($sformatf("r%0d d_done", i), 32'(o_d_done), 32'(tbl[i].dd));
      chk($sformatf("r%0d bus_err", i), 32'(o_bus_err), 32'h0);
      if (tbl[i].chk) begin
        chk($sformatf("r%0d adr", i), o_wb_adr, tbl[i].adr);
        chk($sformatf("r%0d sel", i), 32'(o_wb_sel), 32'(tbl[i].sel));
        chk($sformatf("r%0d we", i), 32'(o_wb_we), 32'(tbl[i].ewe));
        if (tbl[i].ewe || !tbl[i].cyc)
          chk($sformatf("r%0d dat", i), o_wb_dat, tbl[i].edat);
      end
      if (tbl[i].id)
        chk($sformatf("r%0d i_rdata", i), o_i_read_data, tbl[i].rd);
      if (tbl[i].dd)
        chk($sformatf("r%0d d_rdata", i), o_d_read_data, tbl[i].rd);
    end

`ifdef A25_ARB_TIMEOUT_EN
    // never-acked read aborts in the 8th access cycle; then ack meets timeout
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      i_daddress_valid = 1'b1;
      i_daddress       = 32'h400;
      i_write_enable   = 1'b0;
      i_byte_enable    = 4'hF;
      i_wb_ack         = 1'b0;
      i_wb_dat         = 32'hFFFF_FFFF;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (k == 8 && t == 1) begin
          i_wb_ack = 1'b1;
          i_wb_dat = 32'h77;
        end
        #1;
        chk($sformatf("tmo%0d c%0d cyc", t, k), 32'(o_wb_cyc), 32'h1);
        chk($sformatf("tmo%0d c%0d done", t, k), 32'(o_d_done),
            32'(k == 8));
        if (k == 8) begin
          chk($sformatf("tmo%0d err", t), 32'(o_bus_err), 32'(t == 0));
          chk($sformatf("tmo%0d rdata", t), o_d_read_data,
              (t == 0) ? 32'h0 : 32'h77);
        end
      end
      @(negedge clk);
      i_daddress_valid = 1'b0;
      i_wb_ack = 1'b0;
      #1;
      chk($sformatf("tmo%0d cyc_after", t), 32'(o_wb_cyc), 32'h0);
      chk($sformatf("tmo%0d stb_after", t), 32'(o_wb_stb), 32'h0);
    end
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
